// File: rtl/aes_sbox_lanes_if.sv
// Stream bundle for the multi-lane AES S-box engine: input beat with mode,
// output beat with substituted bytes plus echoed input bytes and mode.
interface aes_sbox_lanes_if #(
  parameter int LANES = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_inv;
  logic [8*LANES-1:0]   in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_y;
  logic [8*LANES-1:0]   out_x;
  logic                 out_inv;

  modport master (
    output in_valid, in_inv, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_x, out_inv
  );

  modport slave (
    input  in_valid, in_inv, in_x, out_ready,
    output in_ready, out_valid, out_y, out_x, out_inv
  );
endinterface

// File: rtl/aes_sbox_lanes.sv
// Multi-lane pipelined AES S-box / inverse S-box with valid/ready flow control.
// Latency is exactly PIPE cycles; bubbles collapse and a full pipe still streams.
module aes_sbox_lanes #(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_sbox_lanes_if.slave bus
);
  localparam int W = 8 * LANES;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and maps 0 to 0 for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  // Front half: shared field inversion, preceded by the inverse affine in inverse mode.
  function automatic logic [W-1:0] front_word(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = gf_inv(inv ? affine_inv(x[8*l +: 8]) : x[8*l +: 8]);
    return r;
  endfunction

  // Back half: forward affine, identity in inverse mode.
  function automatic logic [W-1:0] back_word(input logic [W-1:0] t, input logic inv);
    logic [W-1:0] r;
    r = t;
    if (!inv)
      for (int l = 0; l < LANES; l++)
        r[8*l +: 8] = affine_fwd(t[8*l +: 8]);
    return r;
  endfunction

  logic [PIPE-1:0] vld_p;
  logic [PIPE-1:0] ld;
  logic [PIPE-1:0] inv_p;
  logic [W-1:0]    y_p [PIPE];
  logic [W-1:0]    x_p [PIPE];
  logic [W-1:0]    y_in;
  logic            rst_done;

  // A stage loads unless it and every stage after it are full with no drain.
  always_comb begin
    logic full_tail;
    ld        = '0;
    full_tail = 1'b1;
    for (int k = PIPE - 1; k >= 0; k--) begin
      full_tail = full_tail & vld_p[k];
      ld[k]     = !full_tail || bus.out_ready;
    end
  end

  always_comb begin
    y_in = front_word(bus.in_x, bus.in_inv);
    if (PIPE == 1) y_in = back_word(y_in, bus.in_inv);
  end

  // stage control: valid bits and post-reset accept enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      vld_p    <= '0;
    end else begin
      rst_done <= 1'b1;
      if (ld[0]) vld_p[0] <= bus.in_valid && rst_done;
      for (int k = 1; k < PIPE; k++)
        if (ld[k]) vld_p[k] <= vld_p[k-1];
    end
  end

  // stage datapath: partial result, echoed bytes and mode travel together
  always_ff @(posedge clk) begin
    if (ld[0]) begin
      y_p[0]   <= y_in;
      x_p[0]   <= bus.in_x;
      inv_p[0] <= bus.in_inv;
    end
    for (int k = 1; k < PIPE; k++) begin
      if (ld[k]) begin
        y_p[k]   <= (k == PIPE - 1) ? back_word(y_p[k-1], inv_p[k-1]) : y_p[k-1];
        x_p[k]   <= x_p[k-1];
        inv_p[k] <= inv_p[k-1];
      end
    end
  end

  // output stage: data is zero whenever no beat is present
  assign bus.in_ready  = ld[0] && rst_done;
  assign bus.out_valid = vld_p[PIPE-1];
  assign bus.out_y     = vld_p[PIPE-1] ? y_p[PIPE-1]   : '0;
  assign bus.out_x     = vld_p[PIPE-1] ? x_p[PIPE-1]   : '0;
  assign bus.out_inv   = vld_p[PIPE-1] ? inv_p[PIPE-1] : 1'b0;
endmodule

// File: tb/tb_aes_sbox_lanes.sv
// Bench for aes_sbox_lanes: sweeps, mode alternation, backpressure, random flow and reset,
// all scored against an S-box table built from field arithmetic inside the bench.
module tb_aes_sbox_lanes;
  typedef struct {
    logic [127:0] x;
    logic         inv;
    int           cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic lat_on = 1'b0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [7:0] dfwd [256];
  logic [7:0] dinv [256];
  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;
  logic         hold_b = 1'b0;
  logic [127:0] hy, hx;
  logic         hinv;

  aes_sbox_lanes_if #(.LANES(4))  a ();
  aes_sbox_lanes_if #(.LANES(16)) b ();

  aes_sbox_lanes #(.LANES(4),  .PIPE(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  aes_sbox_lanes #(.LANES(16), .PIPE(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial product then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] tb_mul(input logic [7:0] p, input logic [7:0] q);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (q[i]) acc = acc ^ (15'(p) << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (15'h11b << (i - 8));
    return acc[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    logic [7:0] iv;
    logic [7:0] s;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      iv = 8'h00;
      for (int t = 1; t < 256; t++) if (tb_mul(8'(v), 8'(t)) == 8'h01) iv = 8'(t);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      sb[v] = s;
    end
    for (int v = 0; v < 256; v++) isb[sb[v]] = 8'(v);
  endtask

  function automatic logic [127:0] ref_word(input logic [127:0] x, input logic inv, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < 16; l++)
      if (l < lanes) r[8*l +: 8] = inv ? isb[x[8*l +: 8]] : sb[x[8*l +: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) qa.delete();
    else begin
      if (a.out_valid && a.out_ready) begin
        if (qa.size() == 0) chk("a_extra_beat", 128'(a.out_valid), 128'(0));
        else begin
          ea = qa.pop_front();
          chk("a_y", 128'(a.out_y), ref_word(ea.x, ea.inv, 4));
          chk("a_x", 128'(a.out_x), ea.x);
          chk("a_inv", 128'(a.out_inv), 128'(ea.inv));
          if (lat_on) chk("a_latency", 128'(cyc - ea.cyc), 128'(2));
          for (int l = 0; l < 4; l++)
            if (ea.inv) dinv[ea.x[8*l +: 8]] = a.out_y[8*l +: 8];
            else        dfwd[ea.x[8*l +: 8]] = a.out_y[8*l +: 8];
        end
      end
      if (a.in_valid && a.in_ready) qa.push_back('{x: 128'(a.in_x), inv: a.in_inv, cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        chk("b_hold_valid", 128'(b.out_valid), 128'(1));
        chk("b_hold_y", b.out_y, hy);
        chk("b_hold_x", b.out_x, hx);
        chk("b_hold_inv", 128'(b.out_inv), 128'(hinv));
      end
      hold_b = b.out_valid && !b.out_ready;
      hy = b.out_y; hx = b.out_x; hinv = b.out_inv;
      if (b.out_valid && b.out_ready) begin
        if (qb.size() == 0) chk("b_extra_beat", 128'(b.out_valid), 128'(0));
        else begin
          eb = qb.pop_front();
          chk("b_y", b.out_y, ref_word(eb.x, eb.inv, 16));
          chk("b_x", b.out_x, eb.x);
          chk("b_inv", 128'(b.out_inv), 128'(eb.inv));
        end
      end
      if (b.in_valid && b.in_ready) qb.push_back('{x: b.in_x, inv: b.in_inv, cyc: cyc});
    end
  end

  task automatic send_a(input logic [31:0] x, input logic inv);
    int n;
    n = 0;
    a.in_valid = 1'b1; a.in_x = x; a.in_inv = inv;
    @(negedge clk);
    while (!a.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!a.in_ready) chk("a_accept_timeout", 128'(a.in_ready), 128'(1));
    @(posedge clk); #1;
    a.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("a_drained", 128'(qa.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    b.out_ready = 1'b1;
    while (qb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("b_drained", 128'(qb.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] bp [5];

  initial begin
    int acc, outs, gap, ncyc;
    logic pend;
    a.in_valid = 1'b0; a.in_inv = 1'b0; a.in_x = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_inv = 1'b0; b.in_x = '0; b.out_ready = 1'b0;
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", 128'(a.out_valid), 128'(0));
    chk("rst_a_y", 128'(a.out_y), 128'(0));
    chk("rst_a_x", 128'(a.out_x), 128'(0));
    chk("rst_b_valid", 128'(b.out_valid), 128'(0));
    chk("rst_b_inv", 128'(b.out_inv), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_in_ready", 128'(a.in_ready), 128'(1));
    chk("rst_b_in_ready", 128'(b.in_ready), 128'(1));

    // forward and inverse sweeps, continuous flow
    a.out_ready = 1'b1;
    lat_on = 1'b1;
    for (int x = 0; x <= 252; x++) send_a({8'(x + 3), 8'(x + 2), 8'(x + 1), 8'(x)}, 1'b0);
    send_a(32'hFFFEFDFC, 1'b0);
    drain_a();
    chk("S_00", 128'(dfwd[8'h00]), 128'(8'h63));
    chk("S_01", 128'(dfwd[8'h01]), 128'(8'h7C));
    chk("S_53", 128'(dfwd[8'h53]), 128'(8'hED));
    chk("S_FF", 128'(dfwd[8'hFF]), 128'(8'h16));
    for (int x = 0; x <= 252; x++) send_a({8'(x + 3), 8'(x + 2), 8'(x + 1), 8'(x)}, 1'b1);
    send_a(32'hFFFEFDFC, 1'b1);
    drain_a();
    chk("InvS_63", 128'(dinv[8'h63]), 128'(8'h00));
    chk("InvS_00", 128'(dinv[8'h00]), 128'(8'h52));
    chk("InvS_ED", 128'(dinv[8'hED]), 128'(8'h53));
    chk("InvS_16", 128'(dinv[8'h16]), 128'(8'hFF));
    for (int v = 0; v < 256; v++) chk("round_trip", 128'(dinv[dfwd[v]]), 128'(v));

    for (int i = 0; i < 8; i++) send_a(32'h0, 1'(i % 2));
    drain_a();
    lat_on = 1'b0;

    // reset with two beats in flight
    a.out_ready = 1'b0;
    send_a(32'h01234567, 1'b0);
    send_a(32'h89ABCDEF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 128'(a.out_valid), 128'(0));
    chk("rstmid_y", 128'(a.out_y), 128'(0));
    chk("rstmid_x", 128'(a.out_x), 128'(0));
    chk("rstmid_inv", 128'(a.out_inv), 128'(0));
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_in_ready", 128'(a.in_ready), 128'(1));
    repeat (5) begin
      @(negedge clk);
      chk("rstmid_no_stale", 128'(a.out_valid), 128'(0));
    end
    @(posedge clk); #1;

    // backpressure on the PIPE=3 engine
    for (int i = 0; i < 5; i++) bp[i] = rnd128();
    b.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      b.in_valid = 1'b1; b.in_x = bp[acc]; b.in_inv = 1'b0;
      @(negedge clk);
      if (b.in_ready) acc++;
      if (i >= 4) chk("bp_head_x", b.out_x, bp[0]);
      @(posedge clk); #1;
    end
    chk("bp_accepted", 128'(acc), 128'(3));
    chk("bp_in_ready", 128'(b.in_ready), 128'(0));
    b.out_ready = 1'b1;
    outs = 0; gap = 0;
    for (int i = 0; i < 15; i++) begin
      b.in_valid = (acc < 5);
      if (acc < 5) b.in_x = bp[acc];
      @(negedge clk);
      if (b.in_valid && b.in_ready) acc++;
      if (b.out_valid) outs++;
      else if (outs > 0 && outs < 5) gap++;
      @(posedge clk); #1;
    end
    b.in_valid = 1'b0;
    chk("bp_all_in", 128'(acc), 128'(5));
    chk("bp_all_out", 128'(outs), 128'(5));
    chk("bp_no_gap", 128'(gap), 128'(0));

    // random flow on both sides
    acc = 0; ncyc = 0; pend = 1'b0;
    while (acc < 10000 && ncyc < 60000) begin
      if (!pend && $urandom_range(1, 0) == 1) begin
        b.in_x = rnd128(); b.in_inv = 1'($urandom_range(1, 0)); pend = 1'b1;
      end
      b.in_valid = pend;
      b.out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (b.in_valid && b.in_ready) begin acc++; pend = 1'b0; end
      @(posedge clk); #1;
      ncyc++;
    end
    chk("rand_beats", 128'(acc), 128'(10000));

    b.out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 60; i++) begin
      b.in_valid = 1'b1; b.in_x = rnd128(); b.in_inv = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (i >= 10 && b.out_valid) outs++;
      @(posedge clk); #1;
    end
    b.in_valid = 1'b0;
    chk("b_throughput", 128'(outs), 128'(50));
    drain_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
